shift_sequencer: RTL and testbench

- Command-driven controller directly upstream of the 4-bit shift register; generates its mode/enable/inbit/loadval drive.
- Accepts one command per valid/ready handshake (load, hold, shift N times, shift-in N serial bits), steps it out one register operation per clock, then pulses done.
- Its outputs wire straight to the shift register's mode, enable, inbit and loadval inputs.

---
 rtl/shift_sequencer_if.sv | 16 +
 rtl/shift_sequencer.sv | 144 ++++++++++++++
 tb/tb_shift_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Command channel into the shift sequencer: one command per valid/ready handshake.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_count, output cmd_data,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_count, input  cmd_data,
                  output cmd_ready);
endinterface

// File: rtl/shift_sequencer.sv
// Steps one accepted command out as per-cycle mode/enable/inbit/loadval drive
// for the downstream 4-bit shift register, then pulses done.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  shift_sequencer_if.slave cmd,
  output logic [2:0]       mode_o,
  output logic             enable_o,
  output logic             inbit_o,
  output logic [WIDTH-1:0] loadval_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [2:0] MODE_LOAD = 3'b000;
  localparam logic [2:0] MODE_HOLD = 3'b001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       mode_q, mode_d;
  logic             enable_q, enable_d;
  logic             inbit_q, inbit_d;
  logic [WIDTH-1:0] loadval_q, loadval_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] step_bits;
  logic             reserved_in;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    op_d      = op_q;
    data_d    = data_q;
    mode_d    = MODE_HOLD;
    enable_d  = 1'b0;
    inbit_d   = 1'b0;
    loadval_d = loadval_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ready_d   = 1'b0;
    // Steps beyond WIDTH shift zeros in, which the right shift gives for free.
    step_bits   = data_q >> cnt_q;
    reserved_in = (cmd.cmd_op[2:1] == 2'b11);

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (cmd.cmd_valid && ready_q) begin
          ready_d = 1'b0;
          op_d    = cmd.cmd_op;
          data_d  = cmd.cmd_data;
          n_d     = (cmd.cmd_op[2:1] == 2'b00) ? CNT_W'(1) : cmd.cmd_count;
          if (reserved_in || n_d == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = reserved_in;
          end else begin
            // Step 0 issues straight from the handshake so it lands at k+1.
            state_d  = S_RUN;
            cnt_d    = CNT_W'(1);
            mode_d   = cmd.cmd_op;
            enable_d = 1'b1;
            busy_d   = 1'b1;
            inbit_d  = cmd.cmd_op[2] & ~cmd.cmd_op[1] & cmd.cmd_data[0];
            if (cmd.cmd_op == MODE_LOAD) loadval_d = cmd.cmd_data;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == n_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          mode_d   = op_q;
          enable_d = 1'b1;
          busy_d   = 1'b1;
          inbit_d  = op_q[2] & ~op_q[1] & step_bits[0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      op_q      <= '0;
      data_q    <= '0;
      mode_q    <= MODE_HOLD;
      enable_q  <= 1'b0;
      inbit_q   <= 1'b0;
      loadval_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      op_q      <= op_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      enable_q  <= enable_d;
      inbit_q   <= inbit_d;
      loadval_q <= loadval_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign mode_o        = mode_q;
  assign enable_o      = enable_q;
  assign inbit_o       = inbit_q;
  assign loadval_o     = loadval_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the driven shift register.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] mode;
  logic       enable, inbit, busy, done, err;
  logic [3:0] loadval;
  logic [3:0] sreg = 4'b0000;
  int         n_tests = 0;
  int         n_fail = 0;

  shift_sequencer_if #(.WIDTH(4), .CNT_W(3)) cmd_if ();

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .cmd       (cmd_if),
    .mode_o    (mode),
    .enable_o  (enable),
    .inbit_o   (inbit),
    .loadval_o (loadval),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit register fed by the sequencer outputs.
  always_ff @(posedge clk) begin
    if (enable) begin
      case (mode)
        3'b000:  sreg <= loadval;
        3'b010:  sreg <= sreg >> 1;
        3'b011:  sreg <= sreg << 1;
        3'b100:  sreg <= {inbit, sreg[3:1]};
        3'b101:  sreg <= {sreg[2:0], inbit};
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"}, 32'(mode), 32'd1);
    check({tag, "_en"}, 32'(enable), 32'd0);
    check({tag, "_inbit"}, 32'(inbit), 32'd0);
    check({tag, "_ld"}, 32'(loadval), 32'd0);
    check({tag, "_rdy"}, 32'(cmd_if.cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Called at a negedge; offers the command for exactly one edge, then scrambles inputs.
  task automatic send(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data);
    check("ready_pre", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_count = cnt;
    cmd_if.cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'b111;
    cmd_if.cmd_count = ~cnt;
    cmd_if.cmd_data  = ~data;
  endtask

  task automatic expect_run(input string tag, input logic [2:0] op, input int len,
                            input logic [7:0] bits, input logic exp_err, input logic [3:0] ld);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check({tag, "_en"}, 32'(enable), 32'd1);
      check({tag, "_mode"}, 32'(mode), 32'(op));
      check({tag, "_inbit"}, 32'(inbit), 32'(bits[i]));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_ld"}, 32'(loadval), 32'(ld));
      check({tag, "_done_early"}, 32'(done), 32'd0);
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_en_off"}, 32'(enable), 32'd0);
    check({tag, "_mode_hold"}, 32'(mode), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_rdy_done"}, 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    check({tag, "_rdy_idle"}, 32'(cmd_if.cmd_ready), 32'd1);
    check({tag, "_done_off"}, 32'(done), 32'd0);
    check({tag, "_err_off"}, 32'(err), 32'd0);
  endtask

  initial begin
    // Reset with a command offered; it must be dropped.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'b000;
    cmd_if.cmd_count = 3'd0;
    cmd_if.cmd_data  = 4'b1111;
    repeat (2) begin
      @(negedge clk);
      check_reset_vals("rst");
    end
    rst_n = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("idle");
    end

    send(3'b000, 3'd0, 4'b1010);
    expect_run("load", 3'b000, 1, 8'h00, 1'b0, 4'b1010);
    check("load_reg", 32'(sreg), 32'h0A);

    send(3'b000, 3'd5, 4'b0000);
    expect_run("clr", 3'b000, 1, 8'h00, 1'b0, 4'b0000);

    send(3'b101, 3'd4, 4'b0110);
    expect_run("shlin4", 3'b101, 4, 8'b0000_0110, 1'b0, 4'b0000);
    check("shlin4_reg", 32'(sreg), 32'h6);

    send(3'b101, 3'd6, 4'b0110);
    expect_run("shlin6", 3'b101, 6, 8'b0000_0110, 1'b0, 4'b0000);
    check("shlin6_reg", 32'(sreg), 32'h8);

    send(3'b100, 3'd3, 4'b1101);
    expect_run("shrin3", 3'b100, 3, 8'b0000_0101, 1'b0, 4'b0000);
    check("shrin3_reg", 32'(sreg), 32'hB);

    send(3'b010, 3'd2, 4'b1111);
    expect_run("shr2", 3'b010, 2, 8'h00, 1'b0, 4'b0000);
    check("shr2_reg", 32'(sreg), 32'h2);

    send(3'b010, 3'd0, 4'b1111);
    expect_run("shr0", 3'b010, 0, 8'h00, 1'b0, 4'b0000);

    send(3'b011, 3'd7, 4'b1111);
    expect_run("shl7", 3'b011, 7, 8'h00, 1'b0, 4'b0000);
    check("shl7_reg", 32'(sreg), 32'h0);

    send(3'b111, 3'd3, 4'b1111);
    expect_run("rsv7", 3'b111, 0, 8'h00, 1'b1, 4'b0000);
    send(3'b110, 3'd3, 4'b1111);
    expect_run("rsv6", 3'b110, 0, 8'h00, 1'b1, 4'b0000);

    // cmd_valid held high throughout; the load offered while busy must not run.
    check("hs_rdy0", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'b001;
    cmd_if.cmd_count = 3'd0;
    cmd_if.cmd_data  = 4'b0000;
    @(posedge clk);
    #1;
    cmd_if.cmd_op   = 3'b000;
    cmd_if.cmd_data = 4'b1111;
    @(negedge clk);
    check("hs_hold_en", 32'(enable), 32'd1);
    check("hs_hold_mode", 32'(mode), 32'd1);
    check("hs_hold_rdy", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    check("hs_done", 32'(done), 32'd1);
    check("hs_done_en", 32'(enable), 32'd0);
    @(negedge clk);
    check("hs_idle_rdy", 32'(cmd_if.cmd_ready), 32'd1);
    check("hs_idle_en", 32'(enable), 32'd0);
    check("hs_idle_ld", 32'(loadval), 32'h0);
    cmd_if.cmd_data = 4'b0101;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    expect_run("hs_load", 3'b000, 1, 8'h00, 1'b0, 4'b0101);
    check("hs_reg", 32'(sreg), 32'h5);

    // Reset while step 3 of a 7-step shift-in is about to issue.
    send(3'b100, 3'd7, 4'b1111);
    repeat (3) @(negedge clk);
    check("mid_en", 32'(enable), 32'd1);
    check("mid_inbit", 32'(inbit), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("midrst");
    repeat (2) begin
      @(negedge clk);
      check("midrst_nodone", 32'(done), 32'd0);
      check("midrst_noen", 32'(enable), 32'd0);
    end
    send(3'b000, 3'd0, 4'b0011);
    expect_run("post_load", 3'b000, 1, 8'h00, 1'b0, 4'b0011);
    check("post_reg", 32'(sreg), 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
